clock_time_ctrl: RTL and testbench
==================================

# clock_time_ctrl

Timekeeping and time-set controller for the digital clock. It owns the seconds/minutes/hours BCD registers and advances them from an internal one-second tick. A two-button FSM (mode, increment) lets the user set hours and minutes. It also drives per-field blank strobes so the display can blink the field being edited. Outputs feed the display digit-conversion and 7-segment path directly.

## Interface
- TICK_CYCLES, 50_000_000, clk cycles per second; minimum 2.
- BLINK_CYCLES, 12_500_000, clk cycles per blink half-period; minimum 2.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- btn_mode  in  1  mode button level, debounced, synchronous to clk.
- btn_inc  in  1  increment button level, debounced, synchronous to clk.
- hr_tens  out  4  hours tens BCD, 0–2.
- hr_ones  out  4  hours ones BCD, 0–9 (0–3 when hr_tens=2).
- min_tens  out  4  minutes tens BCD, 0–5.
- min_ones  out  4  minutes ones BCD, 0–9.
- sec_tens  out  4  seconds tens BCD, 0–5.
- sec_ones  out  4  seconds ones BCD, 0–9.
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 unused.
- hr_blank  out  1  blank hour digits (blink).
- min_blank  out  1  blank minute digits (blink).
- sec_tick  out  1  one-cycle pulse when seconds advance in RUN.

## Operation
- Reset (rst_n low, asynchronous) sets the following, all held until release:
  - all digits 0 (00:00:00), mode=RUN;
  - tick counter 0, blink counter 0, blink phase 0;
  - hr_blank=min_blank=sec_tick=0;
  - button history registers 0.
- Edge detect: mode_edge = btn_mode & ~btn_mode_q; inc_edge = btn_inc & ~btn_inc_q. btn_*_q registers each cycle. Holding a button produces exactly one edge.
- FSM transitions on mode_edge only: RUN→SET_HR→SET_MIN→RUN. The 11 state is illegal and recovers to RUN next cycle.
- RUN:
  - The tick counter counts 0..TICK_CYCLES-1 and wraps.
  - On the wrap cycle, seconds increment and sec_tick=1 for that cycle.
  - Carry chain, 24-hour: sec 59→00 carries to min; min 59→00 carries to hour; 23:59:59→00:00:00.
  - inc_edge is ignored.
- SET_HR / SET_MIN:
  - The tick counter is held at 0, time is frozen, and sec_tick=0.
  - inc_edge increments only the selected field, modulo, with no carry. Hour 23→00; minute 59→00.
- SET_MIN→RUN: seconds clear to 00 and the tick counter clears to 0, so the first second after exit is a full TICK_CYCLES.
- Simultaneous mode_edge and inc_edge: mode wins and the increment is discarded.
- Blink:
  - In set states the blink counter counts 0..BLINK_CYCLES-1 and toggles the phase on wrap.
  - hr_blank = (mode==SET_HR) & phase; min_blank = (mode==SET_MIN) & phase.
  - Any mode_edge or inc_edge clears the blink counter and phase, so the field is shown immediately.
  - In RUN the counter and phase are held at 0 and both blanks are 0.
- Only BCD-legal values are ever produced. Ones-digit wrap and tens increment occur in the same cycle.

## Timing
- All outputs are registered.
- Button to output: btn high sampled at edge N (btn_q=0) → new mode/digits visible after edge N. Latency is 1 clock from the first high sample.
- Tick: the wrap occurs at the edge where count==TICK_CYCLES-1. Digits and sec_tick update at that edge. Seconds period is exactly TICK_CYCLES clocks.
- Blink half-period is exactly BLINK_CYCLES clocks after the last clear.
- A mode_edge on the same cycle as a RUN tick wrap: the tick is suppressed and time stays as before the edge.
- Reset mid-operation (any state, mid-count): all state returns to reset values immediately. First tick occurs TICK_CYCLES clocks after deassertion.

## Test plan
Use TICK_CYCLES=4, BLINK_CYCLES=3.
1. Reset then run 240 clocks. Expect 00:01:00 and 60 sec_tick pulses spaced 4 clocks apart. Digits are 0 throughout reset.
2. Preload 23:59:59 via set mode, then let it tick. Expect 00:00:00 on the next wrap with a single sec_tick.
3. Run to 00:00:02, then pulse mode, 25× inc, mode, 61× inc, mode. Expect hours 01 (23→00 wrap), minutes 01, seconds 00, mode=RUN. The next tick comes 4 clocks later.
4. In SET_HR, idle 9 clocks. Expect hr_blank pattern 0,0,0,1,1,1,0,0,0 and min_blank=0. An inc at any point clears hr_blank the next cycle.
5. Assert mode and inc rising in the same cycle from SET_HR. Expect mode=SET_MIN with hours and minutes unchanged.
6. Assert rst_n low mid-count at 12:34:56 in SET_MIN. Expect immediate 00:00:00, mode=RUN, blanks 0, and the first sec_tick 4 clocks after release.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - 24-hour BCD timekeeper with two-button time-set FSM and field blink
//
// Purpose: keeps hh:mm:ss in BCD, advanced by an internal one-second tick
// derived from clk. A mode button cycles RUN -> SET_HR -> SET_MIN -> RUN and an
// increment button steps the selected field. The field being edited blinks
// through the hr_blank / min_blank strobes.
//
// Ports:
//   clk                     system clock, rising edge
//   rst_n                   asynchronous active-low reset
//   btn_mode, btn_inc       debounced button levels, synchronous to clk
//   hr_tens .. sec_ones     BCD time digits (registered)
//   mode                    00 RUN, 01 SET_HR, 10 SET_MIN
//   hr_blank, min_blank     blank strobes for the field under edit
//   sec_tick                one-cycle pulse when seconds advance in RUN

module clock_time_ctrl #(
  parameter int unsigned TICK_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       hr_blank,
  output logic       min_blank,
  output logic       sec_tick
);

  localparam int TICK_W  = (TICK_CYCLES  > 2) ? $clog2(TICK_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  mode_e              mode_q, mode_d;
  logic [7:0]         hr_q, hr_d;
  logic [7:0]         min_q, min_d;
  logic [7:0]         sec_q, sec_d;
  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               btn_mode_q, btn_inc_q;
  logic               hr_blank_q, hr_blank_d;
  logic               min_blank_q, min_blank_d;
  logic               sec_tick_q, sec_tick_d;

  logic mode_edge;
  logic inc_edge;

  // BCD 00..59 increment; ones wrap and tens step land in the same cycle.
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  // BCD 00..23 increment.
  function automatic logic [7:0] inc_mod24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  assign mode_edge = btn_mode & ~btn_mode_q;
  assign inc_edge  = btn_inc  & ~btn_inc_q;

  // Mode FSM, timekeeping and tick counter.
  always_comb begin
    mode_d     = mode_q;
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    tick_cnt_d = tick_cnt_q;
    sec_tick_d = 1'b0;

    unique case (mode_q)
      RUN: begin
        if (mode_edge) begin
          // A mode press wins over a coincident tick wrap: time is left as is.
          mode_d     = SET_HR;
          tick_cnt_d = '0;
        end else if (tick_cnt_q == TICK_MAX) begin
          tick_cnt_d = '0;
          sec_tick_d = 1'b1;
          sec_d      = inc_mod60(sec_q);
          if (sec_q == 8'h59) begin
            min_d = inc_mod60(min_q);
            if (min_q == 8'h59) begin
              hr_d = inc_mod24(hr_q);
            end
          end
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
      SET_HR: begin
        tick_cnt_d = '0;
        if (mode_edge) begin
          mode_d = SET_MIN;
        end else if (inc_edge) begin
          hr_d = inc_mod24(hr_q);
        end
      end
      SET_MIN: begin
        tick_cnt_d = '0;
        if (mode_edge) begin
          // Seconds restart so the first second after exit is a full period.
          mode_d = RUN;
          sec_d  = 8'h00;
        end else if (inc_edge) begin
          min_d = inc_mod60(min_q);
        end
      end
      default: begin
        mode_d     = RUN;
        tick_cnt_d = '0;
      end
    endcase
  end

  // Blink phase generator; any button edge restarts it so the field shows at once.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (mode_edge || inc_edge) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (mode_q == SET_HR || mode_q == SET_MIN) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end else begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end
  end

  // Blanks are registered from next-state values so they track mode without lag.
  always_comb begin
    hr_blank_d  = (mode_d == SET_HR)  & phase_d;
    min_blank_d = (mode_d == SET_MIN) & phase_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= RUN;
      hr_q        <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      btn_mode_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
      hr_blank_q  <= 1'b0;
      min_blank_q <= 1'b0;
      sec_tick_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      btn_mode_q  <= btn_mode;
      btn_inc_q   <= btn_inc;
      hr_blank_q  <= hr_blank_d;
      min_blank_q <= min_blank_d;
      sec_tick_q  <= sec_tick_d;
    end
  end

  assign hr_tens   = hr_q[7:4];
  assign hr_ones   = hr_q[3:0];
  assign min_tens  = min_q[7:4];
  assign min_ones  = min_q[3:0];
  assign sec_tens  = sec_q[7:4];
  assign sec_ones  = sec_q[3:0];
  assign mode      = mode_q;
  assign hr_blank  = hr_blank_q;
  assign min_blank = min_blank_q;
  assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - directed self-checking bench for clock_time_ctrl
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] mode;
  logic       hr_blank, min_blank, sec_tick;
  logic [23:0] tm;

  int n_checks = 0;
  int n_fail   = 0;

  clock_time_ctrl #(
    .TICK_CYCLES (4),
    .BLINK_CYCLES(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hr_tens  (hr_tens),
    .hr_ones  (hr_ones),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .mode     (mode),
    .hr_blank (hr_blank),
    .min_blank(min_blank),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  assign tm = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode press: high for one edge, returns at the negedge right after that edge.
  task automatic press_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [8:0] blink_pat;
    blink_pat = 9'b000111000;

    // 1. Reset, then 240 clocks of free run.
    btn_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_time", {8'h0, tm}, 32'h0);
      chk("rst_mode", {30'h0, mode}, 32'h0);
      chk("rst_flags", {29'h0, hr_blank, min_blank, sec_tick}, 32'h0);
    end
    btn_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      chk("t1_tick", {31'h0, sec_tick}, {31'h0, (i % 4) == 0});
    end
    chk("t1_time", {8'h0, tm}, 32'h000100);
    chk("t1_mode", {30'h0, mode}, 32'h0);

    // 2. Preload 23:59 via set mode, run to 23:59:59 then wrap to midnight.
    press_mode();
    chk("t2_sethr", {30'h0, mode}, 32'h1);
    repeat (23) press_inc();
    press_mode();
    chk("t2_setmin", {30'h0, mode}, 32'h2);
    repeat (58) press_inc();
    press_mode();
    chk("t2_exit", {8'h0, tm}, 32'h235900);
    idle(236);
    chk("t2_pre", {8'h0, tm}, 32'h235959);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t2_tick", {31'h0, sec_tick}, {31'h0, i == 4});
    end
    chk("t2_wrap", {8'h0, tm}, 32'h000000);

    // 3. Hour/minute modulo wrap in set mode, seconds cleared on exit.
    idle(8);
    chk("t3_run", {8'h0, tm}, 32'h000002);
    press_mode();
    repeat (25) press_inc();
    chk("t3_hr", {8'h0, tm}, 32'h010002);
    press_mode();
    repeat (61) press_inc();
    press_mode();
    chk("t3_time", {8'h0, tm}, 32'h010100);
    chk("t3_mode", {30'h0, mode}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t3_tick", {31'h0, sec_tick}, {31'h0, i == 4});
    end
    chk("t3_after", {8'h0, tm}, 32'h010101);

    // 4. Blink pattern in SET_HR and clear on increment.
    press_mode();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_hrblank", {31'h0, hr_blank}, {31'h0, blink_pat[8-i]});
      chk("t4_minblank", {31'h0, min_blank}, 32'h0);
    end
    @(negedge clk);
    chk("t4_phase", {31'h0, hr_blank}, 32'h1);
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    chk("t4_clear", {31'h0, hr_blank}, 32'h0);
    chk("t4_inc", {8'h0, tm}, 32'h020101);

    // 5. Mode and increment together: mode wins.
    idle(1);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    chk("t5_mode", {30'h0, mode}, 32'h2);
    chk("t5_time", {8'h0, tm}, 32'h020101);
    chk("t5_blank", {30'h0, hr_blank, min_blank}, 32'h0);

    // 6. Reach 12:34:56, enter SET_MIN, reset mid-count.
    idle(1);
    press_mode();
    chk("t6_exit", {8'h0, tm}, 32'h020100);
    idle(1);
    press_mode();
    repeat (10) press_inc();
    press_mode();
    repeat (33) press_inc();
    press_mode();
    chk("t6_set", {8'h0, tm}, 32'h123400);
    idle(224);
    chk("t6_run", {8'h0, tm}, 32'h123456);
    idle(2);
    press_mode();
    idle(1);
    press_mode();
    idle(4);
    chk("t6_frozen", {8'h0, tm}, 32'h123456);
    chk("t6_setmin", {30'h0, mode}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_time", {8'h0, tm}, 32'h0);
    chk("t6_async_mode", {30'h0, mode}, 32'h0);
    chk("t6_async_flags", {29'h0, hr_blank, min_blank, sec_tick}, 32'h0);
    @(negedge clk);
    chk("t6_hold", {8'h0, tm}, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t6_tick", {31'h0, sec_tick}, {31'h0, i == 4});
    end
    chk("t6_first", {8'h0, tm}, 32'h000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
